// File: rtl/apple_placer_pkg.sv
// Shared types and constants for the apple placer: FSM state encoding and
// the 16-bit Galois LFSR used to pick a random free cell.
package apple_placer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COUNT  = 3'd1,
    PICK   = 3'd2,
    SEARCH = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_POLY  = 16'hB400;
  localparam logic [15:0] LFSR_RESET = 16'hACE1;

  // Right-shifting Galois step: feedback taps applied when the output bit is set.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] shifted_s;
    shifted_s = {1'b0, v[15:1]};
    if (v[0]) begin
      lfsr_step = shifted_s ^ LFSR_POLY;
    end else begin
      lfsr_step = shifted_s;
    end
  endfunction

endpackage

// File: rtl/apple_lfsr.sv
// Random source for apple placement. A seed load wins over a step, and an
// all-zero seed is replaced by 1 so the register can never lock up.
module apple_lfsr
  import apple_placer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  // LFSR state register with load priority over step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= LFSR_RESET;
    end else if (load) begin
      value <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else if (step) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/apple_placer.sv
// Picks a uniformly indexed free cell of a snapshotted playfield: count the
// free cells, reduce the random target modulo that count, then walk to it.
module apple_placer
  import apple_placer_pkg::*;
#(
  parameter  int SIZE_X     = 10,
  parameter  int SIZE_Y     = 10,
  parameter  int CELL_BITS  = 3,
  parameter  int EMPTY_CODE = 0,
  localparam int NCELLS     = SIZE_X * SIZE_Y,
  localparam int SBITS      = $clog2(NCELLS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NCELLS*CELL_BITS-1:0] field,
  input  logic                        start,
  input  logic                        seed_load,
  input  logic [15:0]                 seed,
  output logic                        busy,
  output logic                        valid,
  output logic [SBITS-1:0]            apple_pos,
  output logic                        full
);

  localparam logic [SBITS-1:0] IDX_ZERO = {SBITS{1'b0}};
  localparam logic [SBITS-1:0] IDX_ONE  = {{(SBITS-1){1'b0}}, 1'b1};
  localparam logic [SBITS-1:0] IDX_LAST = SBITS'(NCELLS - 1);
  localparam logic [SBITS:0]   CNT_ZERO = {(SBITS+1){1'b0}};
  localparam logic [SBITS:0]   CNT_ONE  = {{SBITS{1'b0}}, 1'b1};

  state_t                      state_r, state_n;
  logic [NCELLS*CELL_BITS-1:0] snap_r, snap_n;
  logic [SBITS-1:0]            target_r, target_n;
  logic [SBITS:0]              cnt_r, cnt_n;
  logic [SBITS-1:0]            idx_r, idx_n;
  logic [SBITS-1:0]            pos_r, pos_n;
  logic                        full_r, full_n;
  logic                        step_s;
  logic                        cell_free_s;
  logic [15:0]                 lfsr_s;

  apple_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (step_s),
    .load  (seed_load),
    .seed  (seed),
    .value (lfsr_s)
  );

  // Next-state and datapath decisions for the placement FSM.
  always_comb begin
    state_n     = state_r;
    snap_n      = snap_r;
    target_n    = target_r;
    cnt_n       = cnt_r;
    idx_n       = idx_r;
    pos_n       = pos_r;
    full_n      = full_r;
    step_s      = 1'b0;
    cell_free_s = (snap_r[int'(idx_r)*CELL_BITS +: CELL_BITS] == CELL_BITS'(EMPTY_CODE));

    case (state_r)
      IDLE: begin
        if (start) begin
          snap_n   = field;
          target_n = lfsr_s[SBITS-1:0];
          step_s   = 1'b1;
          cnt_n    = CNT_ZERO;
          idx_n    = IDX_ZERO;
          state_n  = COUNT;
        end else begin
          state_n  = IDLE;
        end
      end
      COUNT: begin
        if (cell_free_s) begin
          cnt_n = cnt_r + CNT_ONE;
        end else begin
          cnt_n = cnt_r;
        end
        if (idx_r == IDX_LAST) begin
          idx_n   = IDX_ZERO;
          state_n = PICK;
        end else begin
          idx_n   = idx_r + IDX_ONE;
          state_n = COUNT;
        end
      end
      PICK: begin
        // Repeated subtraction is a cheap modulo; cnt fits in SBITS bits here.
        if (cnt_r == CNT_ZERO) begin
          full_n  = 1'b1;
          pos_n   = IDX_LAST;
          state_n = DONE;
        end else if ({1'b0, target_r} >= cnt_r) begin
          target_n = target_r - cnt_r[SBITS-1:0];
          state_n  = PICK;
        end else begin
          state_n  = SEARCH;
        end
      end
      SEARCH: begin
        idx_n = idx_r + IDX_ONE;
        if (cell_free_s) begin
          if (target_r == IDX_ZERO) begin
            pos_n   = idx_r;
            full_n  = 1'b0;
            state_n = DONE;
          end else begin
            target_n = target_r - IDX_ONE;
            state_n  = SEARCH;
          end
        end else begin
          state_n = SEARCH;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      snap_r   <= {(NCELLS*CELL_BITS){1'b0}};
      target_r <= IDX_ZERO;
      cnt_r    <= CNT_ZERO;
      idx_r    <= IDX_ZERO;
      pos_r    <= IDX_ZERO;
      full_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      snap_r   <= snap_n;
      target_r <= target_n;
      cnt_r    <= cnt_n;
      idx_r    <= idx_n;
      pos_r    <= pos_n;
      full_r   <= full_n;
    end
  end

  assign busy      = (state_r != IDLE);
  assign valid     = (state_r == DONE);
  assign apple_pos = pos_r;
  assign full      = full_r;

endmodule

// File: tb/tb_apple_placer.sv
// Directed scenarios on a 4x4 field; expected results are pushed into a
// scoreboard queue and a monitor compares them whenever valid pulses.
module tb_apple_placer;

  localparam int NC = 16;
  localparam int CB = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [NC*CB-1:0] field;
  logic           start;
  logic           seed_load;
  logic [15:0]    seed;
  logic           busy;
  logic           valid;
  logic [3:0]     apple_pos;
  logic           full;

  typedef struct {
    logic [3:0] pos;
    logic       full;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic prev_valid = 1'b0;

  apple_placer #(.SIZE_X(4), .SIZE_Y(4), .CELL_BITS(3), .EMPTY_CODE(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .field     (field),
    .start     (start),
    .seed_load (seed_load),
    .seed      (seed),
    .busy      (busy),
    .valid     (valid),
    .apple_pos (apple_pos),
    .full      (full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [NC*CB-1:0] mk_field(input logic [15:0] free_mask);
    logic [NC*CB-1:0] f;
    for (int i = 0; i < NC; i++) begin
      f[i*CB +: CB] = free_mask[i] ? 3'd0 : 3'd5;
    end
    return f;
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (prev_valid) chk("valid_width", {31'd0, valid}, 32'd0);
    if (valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("apple_pos", {28'd0, apple_pos}, {28'd0, mon_e.pos});
        chk("full", {31'd0, full}, {31'd0, mon_e.full});
        chk("latency", cyc - accept_cyc, mon_e.lat);
      end
    end
    prev_valid = valid;
  end

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      step_edge();
    end
    if (exp_q.size() != 0) begin
      chk("timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input logic [15:0] mask, input logic do_seed, input logic [15:0] sd,
                     input logic [3:0] p, input logic f, input int lat);
    field = mk_field(mask);
    if (do_seed) begin
      seed      = sd;
      seed_load = 1'b1;
      step_edge();
      seed_load = 1'b0;
    end
    start = 1'b1;
    step_edge();
    accept_cyc = cyc;
    start = 1'b0;
    exp_q.push_back('{p, f, lat});
    chk("busy_running", {31'd0, busy}, 32'd1);
    wait_done();
  endtask

  initial begin
    rst       = 1'b1;
    field     = mk_field(16'hFFFF);
    start     = 1'b0;
    seed_load = 1'b0;
    seed      = 16'h0000;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_pos", {28'd0, apple_pos}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    step_edge();
    step_edge();
    rst = 1'b0;
    step_edge();

    // all free, target 5
    run(16'hFFFF, 1'b1, 16'h0005, 4'd5, 1'b0, 23);
    // cells 3, 9, 12 free: one subtraction, third free cell
    run(16'h1208, 1'b1, 16'h0005, 4'd12, 1'b0, 31);
    // only cell 7 free: five subtractions
    run(16'h0080, 1'b1, 16'h0005, 4'd7, 1'b0, 30);
    // no free cell
    run(16'h0000, 1'b1, 16'h0005, 4'd15, 1'b1, 17);
    repeat (3) step_edge();
    chk("hold_pos", {28'd0, apple_pos}, 32'd15);
    chk("hold_full", {31'd0, full}, 32'd1);
    // zero seed becomes 1
    run(16'hFFFF, 1'b1, 16'h0000, 4'd1, 1'b0, 19);

    // start held through SEARCH, field changed mid-COUNT
    field     = mk_field(16'hFFFF);
    seed      = 16'h0005;
    seed_load = 1'b1;
    step_edge();
    seed_load = 1'b0;
    start     = 1'b1;
    step_edge();
    accept_cyc = cyc;
    exp_q.push_back('{4'd5, 1'b0, 23});
    for (int i = 1; i <= 20; i++) begin
      step_edge();
      if (i == 5) field = mk_field(16'h0000);
    end
    start = 1'b0;
    wait_done();
    repeat (8) step_edge();
    chk("idle_after_held_start", {31'd0, busy}, 32'd0);

    // reset in the middle of SEARCH
    field     = mk_field(16'hFFFF);
    seed      = 16'h0005;
    seed_load = 1'b1;
    step_edge();
    seed_load = 1'b0;
    start     = 1'b1;
    step_edge();
    accept_cyc = cyc;
    start = 1'b0;
    exp_q.push_back('{4'd5, 1'b0, 23});
    repeat (19) step_edge();
    chk("mid_search_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_pos", {28'd0, apple_pos}, 32'd0);
    chk("midrst_full", {31'd0, full}, 32'd0);
    chk("midrst_lfsr", {16'd0, dut.u_lfsr.value}, 32'h0000ACE1);
    step_edge();
    rst = 1'b0;
    repeat (30) step_edge();
    // reset LFSR 0xACE1 gives target 1
    run(16'hFFFF, 1'b0, 16'h0000, 4'd1, 1'b0, 19);

    repeat (5) step_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
